// File: rtl/root_network_interface.sv
// Host-side network interface on the quadtree root router's local port:
// credit-controlled TX injection, RX response buffering and layer-done counting.
module root_network_interface #(
  parameter int unsigned ROUTER_WIDTH = 32,
  parameter int unsigned CREDIT_NUM   = 4,
  parameter int unsigned TX_DEPTH     = 4,
  parameter int unsigned RX_DEPTH     = 4,
  parameter int unsigned NUM_PE       = 64,
  parameter logic [1:0]  TYPE_DONE    = 2'b11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  input  logic [ROUTER_WIDTH-1:0] cmd_data,
  output logic                    cmd_ready,
  output logic                    out_data_valid,
  output logic [ROUTER_WIDTH-1:0] out_data,
  input  logic                    downstream_credit,
  input  logic                    in_data_valid,
  input  logic [ROUTER_WIDTH-1:0] in_data,
  output logic                    upstream_credit,
  output logic                    rsp_valid,
  output logic [ROUTER_WIDTH-1:0] rsp_data,
  input  logic                    rsp_ready,
  output logic                    layer_done,
  output logic                    rx_overflow
);
  localparam int unsigned CW  = $clog2(CREDIT_NUM + 1);
  localparam int unsigned TPW = $clog2(TX_DEPTH);
  localparam int unsigned TCW = $clog2(TX_DEPTH + 1);
  localparam int unsigned RPW = $clog2(RX_DEPTH);
  localparam int unsigned RCW = $clog2(RX_DEPTH + 1);
  localparam int unsigned DW  = $clog2(NUM_PE + 1);

  logic [ROUTER_WIDTH-1:0] tx_mem_q [TX_DEPTH];
  logic [ROUTER_WIDTH-1:0] tx_mem_d [TX_DEPTH];
  logic [TPW-1:0]          tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TCW-1:0]          tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]           credit_cnt_q, credit_cnt_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    out_data_valid_q, out_data_valid_d;
  logic [ROUTER_WIDTH-1:0] out_data_q, out_data_d;
  logic                    tx_push, tx_pop;

  logic [ROUTER_WIDTH-1:0] rx_mem_q [RX_DEPTH];
  logic [ROUTER_WIDTH-1:0] rx_mem_d [RX_DEPTH];
  logic [RPW-1:0]          rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RCW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [DW-1:0]           done_cnt_q, done_cnt_d;
  logic                    upstream_credit_q, upstream_credit_d;
  logic                    layer_done_q, layer_done_d;
  logic                    rx_overflow_q, rx_overflow_d;
  logic                    rx_push, rx_pop, rx_full, is_done;

  // TX FIFO, credit accounting and injection register
  always_comb begin
    tx_push          = cmd_valid && cmd_ready_q;
    tx_pop           = (tx_cnt_q != '0) && (credit_cnt_q != '0);
    tx_mem_d         = tx_mem_q;
    tx_wr_d          = tx_wr_q;
    tx_rd_d          = tx_rd_q;
    tx_cnt_d         = tx_cnt_q + TCW'(tx_push) - TCW'(tx_pop);
    out_data_valid_d = tx_pop;
    out_data_d       = out_data_q;
    credit_cnt_d     = credit_cnt_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_q] = cmd_data;
      tx_wr_d           = tx_wr_q + TPW'(1);
    end
    if (tx_pop) begin
      out_data_d = tx_mem_q[tx_rd_q];
      tx_rd_d    = tx_rd_q + TPW'(1);
    end
    cmd_ready_d = (tx_cnt_d != TCW'(TX_DEPTH));
    if (tx_pop && !downstream_credit) begin
      credit_cnt_d = credit_cnt_q - CW'(1);
    end else if (!tx_pop && downstream_credit && (credit_cnt_q != CW'(CREDIT_NUM))) begin
      credit_cnt_d = credit_cnt_q + CW'(1);
    end
  end

  // RX FIFO, credit return, overflow flag and DONE counting
  always_comb begin
    rx_pop            = (rx_cnt_q != '0) && rsp_ready;
    rx_full           = (rx_cnt_q == RCW'(RX_DEPTH));
    rx_push           = in_data_valid && (!rx_full || rx_pop);
    is_done           = (in_data[ROUTER_WIDTH-1 -: 2] == TYPE_DONE);
    rx_mem_d          = rx_mem_q;
    rx_wr_d           = rx_wr_q;
    rx_rd_d           = rx_rd_q;
    rx_cnt_d          = rx_cnt_q + RCW'(rx_push) - RCW'(rx_pop);
    upstream_credit_d = rx_pop;
    rx_overflow_d     = rx_overflow_q || (in_data_valid && !rx_push);
    done_cnt_d        = done_cnt_q;
    layer_done_d      = 1'b0;
    if (rx_push) begin
      rx_mem_d[rx_wr_q] = in_data;
      rx_wr_d           = rx_wr_q + RPW'(1);
    end
    if (rx_pop) begin
      rx_rd_d = rx_rd_q + RPW'(1);
    end
    if (rx_push && is_done) begin
      if (done_cnt_q == DW'(NUM_PE - 1)) begin
        done_cnt_d   = '0;
        layer_done_d = 1'b1;
      end else begin
        done_cnt_d = done_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= '0;
      for (int unsigned i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= '0;
      tx_wr_q           <= '0;
      tx_rd_q           <= '0;
      tx_cnt_q          <= '0;
      credit_cnt_q      <= CW'(CREDIT_NUM);
      cmd_ready_q       <= 1'b0;
      out_data_valid_q  <= 1'b0;
      out_data_q        <= '0;
      rx_wr_q           <= '0;
      rx_rd_q           <= '0;
      rx_cnt_q          <= '0;
      done_cnt_q        <= '0;
      upstream_credit_q <= 1'b0;
      layer_done_q      <= 1'b0;
      rx_overflow_q     <= 1'b0;
    end else begin
      tx_mem_q          <= tx_mem_d;
      rx_mem_q          <= rx_mem_d;
      tx_wr_q           <= tx_wr_d;
      tx_rd_q           <= tx_rd_d;
      tx_cnt_q          <= tx_cnt_d;
      credit_cnt_q      <= credit_cnt_d;
      cmd_ready_q       <= cmd_ready_d;
      out_data_valid_q  <= out_data_valid_d;
      out_data_q        <= out_data_d;
      rx_wr_q           <= rx_wr_d;
      rx_rd_q           <= rx_rd_d;
      rx_cnt_q          <= rx_cnt_d;
      done_cnt_q        <= done_cnt_d;
      upstream_credit_q <= upstream_credit_d;
      layer_done_q      <= layer_done_d;
      rx_overflow_q     <= rx_overflow_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign out_data_valid  = out_data_valid_q;
  assign out_data        = out_data_q;
  assign upstream_credit = upstream_credit_q;
  assign layer_done      = layer_done_q;
  assign rx_overflow     = rx_overflow_q;
  // Head of the RX FIFO is presented straight from the storage flops
  assign rsp_valid       = (rx_cnt_q != '0);
  assign rsp_data        = rx_mem_q[rx_rd_q];

endmodule
